// File: rtl/cam_cfg_sequencer.sv
// Walks the camera configuration ROM from address 0 and issues one SCCB write
// per table entry; 16'hFFF0 inserts a fixed delay, 16'hFFFF ends the table.
module cam_cfg_sequencer #(
    parameter int          DELAY_CYCLES = 25000,
    parameter logic [7:0]  CAM_ID       = 8'h42,
    parameter int          ROM_AW       = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_sccb_valid,
    input  logic              i_sccb_ready,
    output logic [7:0]        o_sccb_id,
    output logic [7:0]        o_sccb_reg,
    output logic [7:0]        o_sccb_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int                CW       = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CW-1:0]     CNT_LOAD = CW'(DELAY_CYCLES - 1);
    localparam logic [ROM_AW-1:0] ADDR_MAX = '1;
    localparam logic [15:0]       ENT_END  = 16'hFFFF;
    localparam logic [15:0]       ENT_DLY  = 16'hFFF0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_WAIT,
        S_DECODE,
        S_SEND,
        S_DELAY,
        S_END,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Step to the next entry, or finish if the table ran off the ROM's end.
    state_t            adv_state;
    logic [ROM_AW-1:0] adv_addr;

    always_comb begin
        adv_state = S_ROM_WAIT;
        adv_addr  = addr_q + 1'b1;
        if (addr_q == ADDR_MAX) begin
            adv_state = S_END;
            adv_addr  = addr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        reg_d   = reg_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_ROM_WAIT;
                end
            end
            S_ROM_WAIT: state_d = S_DECODE;
            S_DECODE: begin
                if (i_rom_data == ENT_END) begin
                    state_d = S_END;
                end else if (i_rom_data == ENT_DLY) begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_DELAY;
                end else begin
                    reg_d   = i_rom_data[15:8];
                    data_d  = i_rom_data[7:0];
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (i_sccb_ready) begin
                    valid_d = 1'b0;
                    addr_d  = adv_addr;
                    state_d = adv_state;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    addr_d  = adv_addr;
                    state_d = adv_state;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Ready here means the last write has actually left the bus.
            S_END: begin
                if (i_sccb_ready) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_rom_addr   = addr_q;
    assign o_sccb_valid = valid_q;
    assign o_sccb_id    = CAM_ID;
    assign o_sccb_reg   = reg_q;
    assign o_sccb_data  = data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: behavioural registered ROM, scripted and random
// SCCB backpressure, and a scoreboard of expected writes in ROM order.
module tb_cam_cfg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, start, ready;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        valid, busy, done;
    logic [7:0]  sccb_id, sccb_reg, sccb_data;

    logic        s_start, s_ready;
    logic [2:0]  s_addr;
    logic [15:0] s_rom_data;
    logic        s_valid, s_busy, s_done;
    logic [7:0]  s_id, s_reg, s_data;

    cam_cfg_sequencer #(.DELAY_CYCLES(10), .CAM_ID(8'h42), .ROM_AW(8)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_sccb_valid(valid), .i_sccb_ready(ready),
        .o_sccb_id(sccb_id), .o_sccb_reg(sccb_reg), .o_sccb_data(sccb_data),
        .o_busy(busy), .o_done(done)
    );

    cam_cfg_sequencer #(.DELAY_CYCLES(10), .CAM_ID(8'h42), .ROM_AW(3)) dut_s (
        .i_clk(clk), .i_rstn(rstn), .i_start(s_start),
        .o_rom_addr(s_addr), .i_rom_data(s_rom_data),
        .o_sccb_valid(s_valid), .i_sccb_ready(s_ready),
        .o_sccb_id(s_id), .o_sccb_reg(s_reg), .o_sccb_data(s_data),
        .o_busy(s_busy), .o_done(s_done)
    );

    // Behavioural ROMs with one cycle of registered read latency.
    logic [15:0] rom_mem [256];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];
    always @(posedge clk) s_rom_data <= 16'h1234;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int xfer_cnt = 0, s_xfer_cnt = 0;
    int last_xfer_cyc = 0, last_gap = 0;
    logic prev_valid = 1'b0;
    logic [15:0] last_xfer = '0;
    logic [15:0] exp_q[$];
    logic [15:0] exp2_q[$];
    int ready_mode = 0;  // 0: always ready, 1: scripted, 2: random stalls
    int stall_left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            ready = 1'b1;
        end else if (ready_mode == 2) begin
            if (stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else begin
                ready = 1'b1;
                stall_left = $urandom_range(0, 5);
            end
        end
    end

    // Transfer monitor: valid && ready seen at negedge is accepted at the next posedge.
    always @(negedge clk) begin
        if (rstn) begin
            if (valid && !prev_valid) last_gap = cyc - last_xfer_cyc;
            if (valid && ready) begin
                xfer_cnt++;
                last_xfer = {sccb_reg, sccb_data};
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) check("xfer_unexpected", {sccb_reg, sccb_data}, 32'hFFFF_FFFF);
                else check("xfer", {sccb_reg, sccb_data}, exp_q.pop_front());
            end
            if (s_valid && s_ready) begin
                s_xfer_cnt++;
                if (exp2_q.size() == 0) check("s_xfer_unexpected", {s_reg, s_data}, 32'hFFFF_FFFF);
                else check("s_xfer", {s_reg, s_data}, exp2_q.pop_front());
            end
        end
        prev_valid = valid;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int k = 0;
        @(negedge clk);
        while (done !== 1'b1 && k < limit) begin @(negedge clk); k++; end
        check(tag, done, 1);
    endtask

    task automatic wait_xfer(input int n, input int limit);
        int k = 0;
        @(negedge clk);
        while (xfer_cnt < n && k < limit) begin @(negedge clk); k++; end
        check("xfer_timeout", (xfer_cnt >= n), 1);
    endtask

    task automatic wait_valid(input int limit);
        int k = 0;
        @(negedge clk);
        while (valid !== 1'b1 && k < limit) begin @(negedge clk); k++; end
        check("valid_timeout", valid, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, rom_addr, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_reg"}, sccb_reg, 0);
        check({tag, "_data"}, sccb_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = 16'h1280;
        rom_mem[1] = 16'hFFF0;
        rom_mem[2] = 16'h1204;
        rom_mem[3] = 16'hFFFF;
    endtask

    task automatic push_rom_expected();
        for (int i = 0; i < 256; i++) begin
            if (rom_mem[i] == 16'hFFFF) break;
            if (rom_mem[i] != 16'hFFF0) exp_q.push_back(rom_mem[i]);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rstn = 1'b0; start = 1'b0; ready = 1'b1; s_start = 1'b0; s_ready = 1'b1;
        load_basic();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        check("cam_id", sccb_id, 8'h42);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Basic table, always ready: two writes, delay gap, done/busy together.
        xfer_cnt = 0;
        push_rom_expected();
        pulse_start();
        wait_done(200, "t1_done");
        check("t1_busy_at_done", busy, 0);
        check("t1_xfers", xfer_cnt, 2);
        check("t1_gap_ge_delay", (last_gap >= 10), 1);
        check("t1_q_empty", exp_q.size(), 0);

        // Backpressure: first request held for 7 cycles.
        ready_mode = 1; ready = 1'b0; xfer_cnt = 0;
        push_rom_expected();
        pulse_start();
        wait_valid(20);
        for (int i = 0; i < 7; i++) begin
            check("t2_stall_reg", sccb_reg, 8'h12);
            check("t2_stall_data", sccb_data, 8'h80);
            check("t2_stall_addr", rom_addr, 0);
            check("t2_stall_valid", valid, 1);
            if (i < 6) @(negedge clk);
        end
        @(posedge clk); #1;
        ready = 1'b1;
        wait_xfer(1, 20);
        repeat (2) @(negedge clk);
        check("t2_one_xfer", xfer_cnt, 1);
        check("t2_addr_adv", rom_addr, 1);
        ready_mode = 0;
        wait_done(200, "t2_done");
        check("t2_q_empty", exp_q.size(), 0);

        // Production-sized table with random stalls.
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        for (int i = 0; i < 75; i++) rom_mem[i] = {8'(i * 3 + 1), 8'(i * 7 + 5)};
        rom_mem[0] = 16'h1280; rom_mem[20] = 16'hFFF0;
        rom_mem[50] = 16'hFFF0; rom_mem[74] = 16'h13E5;
        xfer_cnt = 0;
        push_rom_expected();
        ready_mode = 2;
        pulse_start();
        wait_done(5000, "t3_done");
        check("t3_xfers", xfer_cnt, 73);
        check("t3_last", last_xfer, 16'h13E5);
        check("t3_addr", rom_addr, 75);
        check("t3_q_empty", exp_q.size(), 0);
        ready_mode = 0;

        // Reset during DELAY, then during SEND with valid high.
        load_basic();
        xfer_cnt = 0;
        push_rom_expected();
        pulse_start();
        wait_xfer(1, 50);
        repeat (4) @(posedge clk); #1;
        do_reset();
        check_zero("t4_rst_delay");
        exp_q.delete();
        ready_mode = 1; ready = 1'b0;
        exp_q.push_back(16'h1280);
        pulse_start();
        wait_valid(20);
        check("t4_reissue", {sccb_reg, sccb_data}, 16'h1280);
        @(posedge clk); #1;
        do_reset();
        check_zero("t4_rst_send");
        exp_q.delete();
        ready_mode = 0; xfer_cnt = 0;
        push_rom_expected();
        pulse_start();
        wait_done(200, "t4_done");
        check("t4_xfers", xfer_cnt, 2);

        // Start while busy is ignored; start in DONE replays the table.
        xfer_cnt = 0;
        push_rom_expected();
        pulse_start();
        begin
            int k = 0;
            @(negedge clk);
            while (rom_addr != 8'd2 && k < 100) begin @(negedge clk); k++; end
            check("t5_reach_addr2", rom_addr, 2);
        end
        pulse_start();
        @(negedge clk);
        check("t5_busy_start_addr", rom_addr, 2);
        check("t5_busy_start_busy", busy, 1);
        wait_done(200, "t5_done");
        check("t5_xfers", xfer_cnt, 2);
        push_rom_expected();
        pulse_start();
        @(negedge clk);
        check("t5_restart_done", done, 0);
        check("t5_restart_addr", rom_addr, 0);
        check("t5_restart_busy", busy, 1);
        wait_done(200, "t5_replay_done");
        check("t5_replay_xfers", xfer_cnt, 4);
        check("t5_q_empty", exp_q.size(), 0);

        // Three-bit ROM with no end marker: 8 writes, then END without wrap.
        for (int i = 0; i < 8; i++) exp2_q.push_back(16'h1234);
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        begin
            int k = 0;
            @(negedge clk);
            while (s_done !== 1'b1 && k < 300) begin @(negedge clk); k++; end
            check("t6_done", s_done, 1);
        end
        check("t6_xfers", s_xfer_cnt, 8);
        check("t6_addr", s_addr, 7);
        repeat (20) @(negedge clk);
        check("t6_no_more_xfers", s_xfer_cnt, 8);
        check("t6_done_held", s_done, 1);
        check("t6_q_empty", exp2_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
